// File: rtl/ahb_cpu_burst_master_if.sv
// rtl/ahb_cpu_burst_master_if.sv - AHB master-side bus bundle for ahb_cpu_burst_master
interface ahb_cpu_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              HBUSREQ;
  logic              HLOCK;
  logic [1:0]        HTRANS;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic              HGRANT;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HADDR, HWRITE, HWDATA,
    input  HGRANT, HREADY, HRDATA
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HADDR, HWRITE, HWDATA,
    output HGRANT, HREADY, HRDATA
  );
endinterface

// File: rtl/ahb_cpu_burst_master.sv
// rtl/ahb_cpu_burst_master.sv - CPU data port to AHB master with one-line read buffer filled by locked INCR bursts
// Optional one-entry posted write buffer: define AHB_BURST_POSTED_WRITE_EN.
module ahb_cpu_burst_master #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter int         BURST_LEN = 4,
  parameter logic [3:0] REGION    = 4'h2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_cpu_burst_master_if.master bus,
  input  logic                  DM_enable,
  input  logic                  DM_write,
  input  logic [ADDR_W-1:0]     DM_address,
  input  logic [DATA_W-1:0]     DM_in,
  input  logic                  stall,
  output logic [DATA_W-1:0]     DM_out,
  output logic                  ready
);
  localparam int BYTES    = DATA_W / 8;
  localparam int WORD_OFF = $clog2(BYTES);
  localparam int OFF_W    = $clog2(BURST_LEN * BYTES);
  localparam int IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LA_W     = ADDR_W - 4;
  localparam int TAG_W    = LA_W - OFF_W;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WADDR, S_WDATA, S_RADDR, S_RBURST, S_RLAST, S_DONE
  } state_t;

  state_t            state, next_state;
  logic [LA_W-1:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] line_buf [BURST_LEN];

  logic [TAG_W-1:0]  dm_tag, req_tag;
  logic [IDX_W-1:0]  dm_idx, req_idx, beat;
  logic              hit, req_hit;
  logic [LA_W-1:0]   line_base, beat_addr;
  logic [DATA_W-1:0] fill_word;
  logic              unused_top;

  assign unused_top = ^DM_address[ADDR_W-1:LA_W];

  assign dm_tag    = DM_address[LA_W-1:OFF_W];
  assign dm_idx    = IDX_W'(DM_address[OFF_W-1:0] >> WORD_OFF);
  assign hit       = valid_q && (tag_q == dm_tag);
  assign req_tag   = addr_q[LA_W-1:OFF_W];
  assign req_idx   = IDX_W'(addr_q[OFF_W-1:0] >> WORD_OFF);
  assign req_hit   = valid_q && (tag_q == req_tag);
  assign line_base = {addr_q[LA_W-1:OFF_W], {OFF_W{1'b0}}};
  // RBURST drives the address of the beat after the one whose data is returning.
  assign beat      = (state == S_RBURST) ? cnt + IDX_W'(1) : '0;
  assign beat_addr = line_base + (LA_W'(beat) << WORD_OFF);
  // The final beat arrives on HRDATA in RLAST and is not yet in the buffer.
  assign fill_word = (req_idx == cnt) ? bus.HRDATA : line_buf[req_idx];

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (DM_enable && (DM_write || !hit)) next_state = S_REQ;
      S_REQ:    if (bus.HGRANT && bus.HREADY) next_state = write_q ? S_WADDR : S_RADDR;
      S_WADDR:  if (bus.HREADY) next_state = S_WDATA;
`ifdef AHB_BURST_POSTED_WRITE_EN
      S_WDATA:  if (bus.HREADY) next_state = S_IDLE;
`else
      S_WDATA:  if (bus.HREADY) next_state = stall ? S_DONE : S_IDLE;
`endif
      S_RADDR:  if (bus.HREADY) next_state = (BURST_LEN == 1) ? S_RLAST : S_RBURST;
      S_RBURST: if (bus.HREADY && cnt == IDX_W'(BURST_LEN - 2)) next_state = S_RLAST;
      S_RLAST:  if (bus.HREADY) next_state = stall ? S_DONE : S_IDLE;
      S_DONE:   if (!stall) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.HBUSREQ = 1'b0;
    bus.HLOCK   = 1'b0;
    bus.HTRANS  = T_IDLE;
    bus.HADDR   = '0;
    bus.HWRITE  = 1'b0;
    bus.HWDATA  = '0;
    ready       = 1'b0;
    DM_out      = dout_q;
    if (HRESET) begin
      ready = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!DM_enable) begin
            ready = 1'b1;
          end else if (!DM_write && hit) begin
            ready  = 1'b1;
            DM_out = line_buf[dm_idx];
          end else begin
            bus.HBUSREQ = 1'b1;
            bus.HLOCK   = ~DM_write;
`ifdef AHB_BURST_POSTED_WRITE_EN
            ready       = DM_write;
`endif
          end
        end
        S_REQ: begin
          bus.HBUSREQ = 1'b1;
          bus.HLOCK   = ~write_q;
`ifdef AHB_BURST_POSTED_WRITE_EN
          ready       = !DM_enable;
`endif
        end
        S_WADDR: begin
          bus.HBUSREQ = 1'b1;
          bus.HTRANS  = T_NONSEQ;
          bus.HWRITE  = 1'b1;
          bus.HADDR   = {REGION, addr_q};
`ifdef AHB_BURST_POSTED_WRITE_EN
          ready       = !DM_enable;
`endif
        end
        S_WDATA: begin
          bus.HWDATA = wdata_q;
`ifdef AHB_BURST_POSTED_WRITE_EN
          ready      = !DM_enable;
`else
          ready      = bus.HREADY;
`endif
        end
        S_RADDR: begin
          bus.HBUSREQ = 1'b1;
          bus.HLOCK   = 1'b1;
          bus.HTRANS  = T_NONSEQ;
          bus.HADDR   = {REGION, line_base};
        end
        S_RBURST: begin
          bus.HLOCK  = 1'b1;
          bus.HTRANS = T_SEQ;
          bus.HADDR  = {REGION, beat_addr};
        end
        S_RLAST: begin
          if (bus.HREADY) begin
            ready  = 1'b1;
            DM_out = fill_word;
          end
        end
        S_DONE: ready = 1'b1;
        default: ready = 1'b1;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      cnt     <= '0;
      dout_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (DM_enable) begin
            addr_q  <= DM_address[LA_W-1:0];
            wdata_q <= DM_in;
            write_q <= DM_write;
            if (!DM_write && hit) dout_q <= line_buf[dm_idx];
          end
        end
        S_RADDR:  cnt <= '0;
        S_RBURST: if (bus.HREADY) cnt <= cnt + IDX_W'(1);
        S_RLAST: begin
          if (bus.HREADY) begin
            valid_q <= 1'b1;
            tag_q   <= req_tag;
            dout_q  <= fill_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      if ((state == S_RBURST || state == S_RLAST) && bus.HREADY)
        line_buf[cnt] <= bus.HRDATA;
      else if (state == S_WDATA && bus.HREADY && req_hit)
        line_buf[req_idx] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_ahb_cpu_burst_master.sv
// tb/tb_ahb_cpu_burst_master.sv - directed self-checking bench for ahb_cpu_burst_master
module tb_ahb_cpu_burst_master;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        DM_enable = 1'b0;
  logic        DM_write = 1'b0;
  logic [31:0] DM_address = '0;
  logic [31:0] DM_in = '0;
  logic        stall = 1'b0;
  logic [31:0] DM_out;
  logic        ready;
  logic        hready = 1'b1;

  always #5 HCLK = ~HCLK;

  ahb_cpu_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_cpu_burst_master #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4), .REGION(4'h2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
    .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
    .DM_in(DM_in), .stall(stall), .DM_out(DM_out), .ready(ready)
  );

  // Memory slave: word at byte address a holds 0xA500_0000 | a.
  logic [31:0] mem [256];
  logic [7:0]  dp_idx;
  logic        dp_valid, dp_write;

  assign bus.HGRANT = 1'b1;
  assign bus.HREADY = hready;
  assign bus.HRDATA = (hready && dp_valid && !dp_write) ? mem[dp_idx] : 32'hBAD0_BAD0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | (i << 2);
    end else if (hready) begin
      if (dp_valid && dp_write) mem[dp_idx] <= bus.HWDATA;
      dp_valid <= bus.HTRANS[1];
      dp_write <= bus.HWRITE;
      dp_idx   <= bus.HADDR[9:2];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_chk(input string tag, input logic [1:0] tr, input logic lk, input logic rq);
    check({tag, ".htrans"}, bus.HTRANS, tr);
    check({tag, ".hlock"}, bus.HLOCK, lk);
    check({tag, ".hbusreq"}, bus.HBUSREQ, rq);
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic cpu(input logic en, input logic wr, input logic [31:0] a, input logic [31:0] d);
    DM_enable  = en;
    DM_write   = wr;
    DM_address = a;
    DM_in      = d;
    #1;
  endtask

  initial begin
    tick; tick;
    check("rst.ready", ready, 1'b1);
    check("rst.dm_out", DM_out, 32'h0);
    check("rst.haddr", bus.HADDR, 32'h0);
    check("rst.hwrite", bus.HWRITE, 1'b0);
    bus_chk("rst", 2'd0, 1'b0, 1'b0);
    HRESET = 1'b0;
    tick;

    // Test 1: miss on empty buffer, full line fill.
    cpu(1, 0, 32'h0000_0108, 0);
    check("t1.idle.ready", ready, 1'b0);
    bus_chk("t1.idle", 2'd0, 1'b1, 1'b1);
    tick; bus_chk("t1.req", 2'd0, 1'b1, 1'b1);
    tick; bus_chk("t1.raddr", 2'd2, 1'b1, 1'b1);
    check("t1.a0", bus.HADDR, 32'h2000_0100);
    tick; bus_chk("t1.b1", 2'd3, 1'b1, 1'b0);
    check("t1.a1", bus.HADDR, 32'h2000_0104);
    tick; check("t1.a2", bus.HADDR, 32'h2000_0108);
    tick; bus_chk("t1.b3", 2'd3, 1'b1, 1'b0);
    check("t1.a3", bus.HADDR, 32'h2000_010C);
    tick; bus_chk("t1.rlast", 2'd0, 1'b0, 1'b0);
    check("t1.ready", ready, 1'b1);
    check("t1.dm_out", DM_out, 32'hA500_0108);

    // Test 2: hit in the freshly filled line.
    tick; cpu(1, 0, 32'h0000_010C, 0);
    check("t2.ready", ready, 1'b1);
    check("t2.dm_out", DM_out, 32'hA500_010C);
    bus_chk("t2", 2'd0, 1'b0, 1'b0);
    tick; bus_chk("t2.next", 2'd0, 1'b0, 1'b0);

    // Test 3: write-through into the buffered line, then read back.
    cpu(1, 1, 32'h0000_0104, 32'hDEAD_BEEF);
    check("t3.idle.ready", ready, 1'b0);
    bus_chk("t3.idle", 2'd0, 1'b0, 1'b1);
    tick;
    tick; check("t3.waddr.htrans", bus.HTRANS, 2'd2);
    check("t3.waddr.hwrite", bus.HWRITE, 1'b1);
    check("t3.waddr.haddr", bus.HADDR, 32'h2000_0104);
    tick; check("t3.wdata.htrans", bus.HTRANS, 2'd0);
    check("t3.wdata.hwdata", bus.HWDATA, 32'hDEAD_BEEF);
    check("t3.wdata.ready", ready, 1'b1);
    tick; cpu(1, 0, 32'h0000_0104, 0);
    check("t3.rd.ready", ready, 1'b1);
    check("t3.rd.dm_out", DM_out, 32'hDEAD_BEEF);
    bus_chk("t3.rd", 2'd0, 1'b0, 1'b0);
    check("t3.mem", mem[8'h41], 32'hDEAD_BEEF);

    // Test 4: wait states during the data phase of beat 1.
    tick; cpu(1, 0, 32'h0000_0208, 0);
    check("t4.idle.ready", ready, 1'b0);
    tick;
    tick; check("t4.a0", bus.HADDR, 32'h2000_0200);
    tick; check("t4.a1", bus.HADDR, 32'h2000_0204);
    tick; hready = 1'b0; #1;
    check("t4.w0.htrans", bus.HTRANS, 2'd3);
    check("t4.w0.haddr", bus.HADDR, 32'h2000_0208);
    for (int k = 1; k < 3; k++) begin
      tick;
      check($sformatf("t4.w%0d.htrans", k), bus.HTRANS, 2'd3);
      check($sformatf("t4.w%0d.haddr", k), bus.HADDR, 32'h2000_0208);
    end
    tick; hready = 1'b1; #1;
    check("t4.resume.haddr", bus.HADDR, 32'h2000_0208);
    tick; check("t4.a3", bus.HADDR, 32'h2000_020C);
    tick; check("t4.rlast.ready", ready, 1'b1);
    check("t4.rlast.dm_out", DM_out, 32'hA500_0208);
    tick; cpu(1, 0, 32'h0000_0204, 0);
    check("t4.hit1.dm_out", DM_out, 32'hA500_0204);
    cpu(1, 0, 32'h0000_0200, 0);
    check("t4.hit0.dm_out", DM_out, 32'hA500_0200);
    cpu(1, 0, 32'h0000_020C, 0);
    check("t4.hit3.dm_out", DM_out, 32'hA500_020C);
    check("t4.hit3.ready", ready, 1'b1);

    // Test 5: stall held over RLAST completion.
    stall = 1'b1;
    cpu(1, 0, 32'h0000_0300, 0);
    for (int k = 0; k < 6; k++) tick;
    check("t5.rlast.ready", ready, 1'b1);
    check("t5.rlast.dm_out", DM_out, 32'hA500_0300);
    for (int k = 0; k < 3; k++) begin
      tick;
      if (k == 1) cpu(1, 0, 32'h0000_0108, 0);
      if (k == 2) begin stall = 1'b0; #1; end
      check($sformatf("t5.done%0d.ready", k), ready, 1'b1);
      check($sformatf("t5.done%0d.dm_out", k), DM_out, 32'hA500_0300);
      check($sformatf("t5.done%0d.htrans", k), bus.HTRANS, 2'd0);
    end
    tick; cpu(1, 0, 32'h0000_0304, 0);
    check("t5.idle.ready", ready, 1'b1);
    check("t5.idle.dm_out", DM_out, 32'hA500_0304);

    // Test 6: reset mid-burst aborts and invalidates the buffer.
    cpu(1, 0, 32'h0000_0400, 0);
    tick;
    tick;
    tick; check("t6.rburst.htrans", bus.HTRANS, 2'd3);
    HRESET = 1'b1;
    cpu(0, 0, 32'h0, 0);
    tick; HRESET = 1'b0; #1;
    bus_chk("t6.after", 2'd0, 1'b0, 1'b0);
    check("t6.after.ready", ready, 1'b1);
    // Line 0x300 was valid before reset; it must miss now.
    cpu(1, 0, 32'h0000_0304, 0);
    check("t6.miss.ready", ready, 1'b0);
    check("t6.miss.hbusreq", bus.HBUSREQ, 1'b1);
    tick;
    tick; check("t6.raddr.haddr", bus.HADDR, 32'h2000_0300);
    tick; tick; tick;
    tick; check("t6.rlast.ready", ready, 1'b1);
    check("t6.rlast.dm_out", DM_out, 32'hA500_0304);
    tick; cpu(0, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
